// File: rtl/reg_file_pkg.sv
// Shared definitions for the CPU register bank: default geometry, the
// reserved zero-register index, read-source selector and index helpers.
package reg_file_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  // Architectural index of the hard-wired zero register (when enabled).
  localparam int REG_ZERO = 0;

  // Where a read port takes its value from in a given cycle.
  typedef enum logic [1:0] {
    RD_SRC_MEM    = 2'd0,
    RD_SRC_BYPASS = 2'd1,
    RD_SRC_ZERO   = 2'd2
  } rd_src_e;

  // Address width for a bank of 'depth' registers (never below one bit).
  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // True when 'idx' names real storage: inside the bank and not the
  // hard-wired zero register. Writes, issues and reads elsewhere are inert.
  function automatic logic idx_writable(input int idx, input int depth, input bit zero_reg);
    return (idx < depth) && !(zero_reg && (idx == REG_ZERO));
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// Bus between issue/writeback and the register bank. The master side is the
// pipeline (drives addresses, strobes and write data); the slave side is the
// register bank (returns read data and busy flags).
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) ();

  localparam int ADDR_W = addr_w(DEPTH);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic [ADDR_W-1:0] rd0_addr;
  logic [WIDTH-1:0]  rd0_data;
  logic              rd0_busy;
  logic [ADDR_W-1:0] rd1_addr;
  logic [WIDTH-1:0]  rd1_data;
  logic              rd1_busy;

  modport master (
    output wr_en, wr_addr, wr_data, iss_en, iss_addr, rd0_addr, rd1_addr,
    input  rd0_data, rd0_busy, rd1_data, rd1_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, iss_en, iss_addr, rd0_addr, rd1_addr,
    output rd0_data, rd0_busy, rd1_data, rd1_busy
  );

endinterface

// File: rtl/reg_file_rd_port.sv
// One combinational read port: selects the addressed word and pending bit,
// forwards same-cycle write data when bypass is enabled, and forces zero for
// the zero register or indices beyond the bank.
module reg_file_rd_port
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  parameter int ADDR_W   = addr_w(DEPTH)
) (
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [WIDTH-1:0]  mem_i [DEPTH],
  input  logic [DEPTH-1:0]  pending_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  output logic [WIDTH-1:0]  rd_data_o,
  output logic              rd_busy_o
);

  logic [WIDTH-1:0] word_sel;
  logic             pend_sel;
  rd_src_e          src;

  // Pick the addressed word and pending bit; unmatched indices leave zeros,
  // so out-of-range addresses never index past the array.
  always_comb begin
    word_sel = '0;
    pend_sel = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr_i == ADDR_W'(i)) begin
        word_sel = mem_i[i];
        pend_sel = pending_i[i];
      end
    end
  end

  // Decide the value source: forced zero beats bypass, bypass beats storage.
  always_comb begin
    src = RD_SRC_MEM;
    if (!idx_writable(int'(rd_addr_i), DEPTH, ZERO_REG != 0)) begin
      src = RD_SRC_ZERO;
    end else if ((BYPASS != 0) && wr_en_i && (wr_addr_i == rd_addr_i)) begin
      src = RD_SRC_BYPASS;
    end
  end

  // Drive data and busy from the chosen source; a bypassed operand is ready.
  always_comb begin
    rd_data_o = word_sel;
    rd_busy_o = pend_sel;
    unique case (src)
      RD_SRC_ZERO: begin
        rd_data_o = '0;
        rd_busy_o = 1'b0;
      end
      RD_SRC_BYPASS: begin
        rd_data_o = wr_data_i;
        rd_busy_o = 1'b0;
      end
      default: begin
        rd_data_o = word_sel;
        rd_busy_o = pend_sel;
      end
    endcase
  end

endmodule

// File: rtl/reg_file.sv
// CPU register bank with one write port, two read ports and a per-register
// pending scoreboard. Issue marks a destination pending, writeback stores the
// value and clears it; when both hit the same register in one cycle the new
// producer wins and the register stays pending.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);

  localparam int ADDR_W = addr_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;
  logic             wr_ok;
  logic             iss_ok;

  // Qualify strobes: zero register and out-of-range indices are discarded.
  always_comb begin
    wr_ok  = bus.wr_en  && idx_writable(int'(bus.wr_addr),  DEPTH, ZERO_REG != 0);
    iss_ok = bus.iss_en && idx_writable(int'(bus.iss_addr), DEPTH, ZERO_REG != 0);
  end

  // Next state: writeback stores and clears pending, then issue sets pending
  // so a same-register collision leaves the newer producer outstanding.
  always_comb begin
    mem_d     = mem_q;
    pending_d = pending_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_ok && (bus.wr_addr == ADDR_W'(i))) begin
        mem_d[i]     = bus.wr_data;
        pending_d[i] = 1'b0;
      end
      if (iss_ok && (bus.iss_addr == ADDR_W'(i))) begin
        pending_d[i] = 1'b1;
      end
    end
  end

  // State register: reset clears every word and pending bit, overriding strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      mem_q     <= mem_d;
      pending_q <= pending_d;
    end
  end

  reg_file_rd_port #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS),
    .ADDR_W   (ADDR_W)
  ) u_rd0 (
    .rd_addr_i (bus.rd0_addr),
    .mem_i     (mem_q),
    .pending_i (pending_q),
    .wr_en_i   (bus.wr_en),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .rd_data_o (bus.rd0_data),
    .rd_busy_o (bus.rd0_busy)
  );

  reg_file_rd_port #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS),
    .ADDR_W   (ADDR_W)
  ) u_rd1 (
    .rd_addr_i (bus.rd1_addr),
    .mem_i     (mem_q),
    .pending_i (pending_q),
    .wr_en_i   (bus.wr_en),
    .wr_addr_i (bus.wr_addr),
    .wr_data_i (bus.wr_data),
    .rd_data_o (bus.rd1_data),
    .rd_busy_o (bus.rd1_busy)
  );

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file. Two instances share the same stimulus:
//   A: DEPTH 8, ZERO_REG 0, BYPASS 1 (default configuration)
//   B: DEPTH 6, ZERO_REG 1, BYPASS 0 (indices 6 and 7 are out of range)
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_reg_file;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_file_if #(.WIDTH(8), .DEPTH(8)) bus_a ();
  reg_file_if #(.WIDTH(8), .DEPTH(6)) bus_b ();

  reg_file #(.WIDTH(8), .DEPTH(8), .ZERO_REG(0), .BYPASS(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  reg_file #(.WIDTH(8), .DEPTH(6), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays of register contents and pending flags.
  int         depth_c [2] = '{8, 6};
  bit         zreg_c  [2] = '{1'b0, 1'b1};
  bit         byp_c   [2] = '{1'b1, 1'b0};
  logic [7:0] mdata [2][8];
  bit         mpend [2][8];
  bit         model_valid = 1'b0;

  // Sampled outputs [instance][port].
  logic [7:0] s_data [2][2];
  logic       s_busy [2][2];

  typedef struct {
    bit         chk;
    bit         r;
    bit         we;
    int         wa;
    logic [7:0] wd;
    bit         ie;
    int         ia;
    int         a0;
    int         a1;
    logic [7:0] d0;
    bit         b0;
    logic [7:0] d1;
    bit         b1;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit real_reg(input int inst, input int a);
    return (a < depth_c[inst]) && !(zreg_c[inst] && a == 0);
  endfunction

  task automatic model_read(input int inst, input int a, input bit we, input int wa,
                            input logic [7:0] wd, output logic [7:0] d, output logic b);
    if (!real_reg(inst, a)) begin
      d = 8'h00;
      b = 1'b0;
    end else if (byp_c[inst] && we && wa == a) begin
      d = wd;
      b = 1'b0;
    end else begin
      d = mdata[inst][a];
      b = mpend[inst][a];
    end
  endtask

  // One clock: drive, sample, compare both instances to the model, advance model.
  task automatic cycle(input bit r, input bit we, input int wa, input logic [7:0] wd,
                       input bit ie, input int ia, input int a0, input int a1);
    logic [7:0] ed;
    logic       eb;
    int         addr;
    @(negedge clk);
    rst = r;
    bus_a.wr_en = we;  bus_a.wr_addr = 3'(wa);  bus_a.wr_data = wd;
    bus_a.iss_en = ie; bus_a.iss_addr = 3'(ia);
    bus_a.rd0_addr = 3'(a0); bus_a.rd1_addr = 3'(a1);
    bus_b.wr_en = we;  bus_b.wr_addr = 3'(wa);  bus_b.wr_data = wd;
    bus_b.iss_en = ie; bus_b.iss_addr = 3'(ia);
    bus_b.rd0_addr = 3'(a0); bus_b.rd1_addr = 3'(a1);
    #1;
    s_data[0][0] = bus_a.rd0_data; s_busy[0][0] = bus_a.rd0_busy;
    s_data[0][1] = bus_a.rd1_data; s_busy[0][1] = bus_a.rd1_busy;
    s_data[1][0] = bus_b.rd0_data; s_busy[1][0] = bus_b.rd0_busy;
    s_data[1][1] = bus_b.rd1_data; s_busy[1][1] = bus_b.rd1_busy;
    if (model_valid && !(r && we)) begin
      for (int i = 0; i < 2; i++) begin
        for (int p = 0; p < 2; p++) begin
          addr = (p == 0) ? a0 : a1;
          model_read(i, addr, we, wa, wd, ed, eb);
          check($sformatf("model inst%0d rd%0d_data addr=%0d", i, p, addr), s_data[i][p], ed);
          check($sformatf("model inst%0d rd%0d_busy addr=%0d", i, p, addr), 8'(s_busy[i][p]), 8'(eb));
        end
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        for (int k = 0; k < 8; k++) begin
          mdata[i][k] = 8'h00;
          mpend[i][k] = 1'b0;
        end
      end else begin
        if (we && real_reg(i, wa)) begin
          mdata[i][wa] = wd;
          mpend[i][wa] = 1'b0;
        end
        if (ie && real_reg(i, ia)) mpend[i][ia] = 1'b1;
      end
    end
    if (r) model_valid = 1'b1;
  endtask

  task automatic idle(input int a0, input int a1);
    cycle(1'b0, 1'b0, 0, 8'h00, 1'b0, 0, a0, a1);
  endtask

  initial begin
    bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    bus_a.iss_en = 1'b0; bus_a.iss_addr = '0; bus_a.rd0_addr = '0; bus_a.rd1_addr = '0;
    bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
    bus_b.iss_en = 1'b0; bus_b.iss_addr = '0; bus_b.rd0_addr = '0; bus_b.rd1_addr = '0;

    // chk, r, we, wa, wd, ie, ia, a0, a1, exp A: d0, b0, d1, b1
    tbl[0]  = '{0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0};
    tbl[1]  = '{1, 0, 1, 3, 8'hA5, 0, 0, 3, 3, 8'hA5, 0, 8'hA5, 0};
    tbl[2]  = '{1, 1, 0, 0, 8'h00, 0, 0, 3, 0, 8'hA5, 0, 8'h00, 0};
    tbl[3]  = '{1, 0, 0, 0, 8'h00, 0, 0, 3, 5, 8'h00, 0, 8'h00, 0};
    tbl[4]  = '{1, 0, 1, 5, 8'h3C, 0, 0, 1, 2, 8'h00, 0, 8'h00, 0};
    tbl[5]  = '{1, 0, 0, 0, 8'h00, 0, 0, 5, 5, 8'h3C, 0, 8'h3C, 0};
    tbl[6]  = '{1, 0, 1, 2, 8'h7E, 0, 0, 3, 2, 8'h00, 0, 8'h7E, 0};
    tbl[7]  = '{1, 0, 0, 0, 8'h00, 1, 4, 4, 2, 8'h00, 0, 8'h7E, 0};
    tbl[8]  = '{1, 0, 0, 0, 8'h00, 0, 0, 4, 4, 8'h00, 1, 8'h00, 1};
    tbl[9]  = '{1, 0, 1, 4, 8'h11, 0, 0, 4, 2, 8'h11, 0, 8'h7E, 0};
    tbl[10] = '{1, 0, 0, 0, 8'h00, 0, 0, 4, 4, 8'h11, 0, 8'h11, 0};
    tbl[11] = '{1, 0, 1, 6, 8'h22, 1, 6, 6, 5, 8'h22, 0, 8'h3C, 0};
    tbl[12] = '{1, 0, 0, 0, 8'h00, 0, 0, 6, 6, 8'h22, 1, 8'h22, 1};
    tbl[13] = '{1, 0, 1, 0, 8'hFF, 1, 0, 0, 6, 8'hFF, 0, 8'h22, 1};
    tbl[14] = '{1, 0, 0, 0, 8'h00, 0, 0, 0, 7, 8'hFF, 1, 8'h00, 0};
    tbl[15] = '{0, 1, 1, 7, 8'h99, 0, 0, 7, 0, 8'h00, 0, 8'h00, 0};
    tbl[16] = '{1, 0, 0, 0, 8'h00, 0, 0, 7, 0, 8'h00, 0, 8'h00, 0};

    for (int n = 0; n < 17; n++) begin
      cycle(tbl[n].r, tbl[n].we, tbl[n].wa, tbl[n].wd, tbl[n].ie, tbl[n].ia, tbl[n].a0, tbl[n].a1);
      if (tbl[n].chk) begin
        check($sformatf("vec%0d rd0_data", n), s_data[0][0], tbl[n].d0);
        check($sformatf("vec%0d rd0_busy", n), 8'(s_busy[0][0]), 8'(tbl[n].b0));
        check($sformatf("vec%0d rd1_data", n), s_data[0][1], tbl[n].d1);
        check($sformatf("vec%0d rd1_busy", n), 8'(s_busy[0][1]), 8'(tbl[n].b1));
      end
    end

    // r5 holds its value across 10 idle cycles.
    cycle(1'b0, 1'b1, 5, 8'h3C, 1'b0, 0, 0, 0);
    for (int n = 0; n < 10; n++) begin
      idle(5, 5);
      check($sformatf("hold A r5 cycle %0d", n), s_data[0][0], 8'h3C);
      check($sformatf("hold B r5 cycle %0d", n), s_data[1][1], 8'h3C);
    end

    // Zero register: writes and issues to r0 are dropped on B, kept on A.
    cycle(1'b0, 1'b1, 0, 8'hFF, 1'b1, 0, 0, 0);
    idle(0, 0);
    check("zero B rd0_data", s_data[1][0], 8'h00);
    check("zero B rd0_busy", 8'(s_busy[1][0]), 8'h00);
    check("zero A rd0_data", s_data[0][0], 8'hFF);
    check("zero A rd0_busy", 8'(s_busy[0][0]), 8'h01);

    // No-bypass B returns old data and stored busy during a write; A forwards.
    cycle(1'b0, 1'b1, 2, 8'h44, 1'b0, 0, 0, 0);
    cycle(1'b0, 1'b0, 0, 8'h00, 1'b1, 2, 0, 0);
    cycle(1'b0, 1'b1, 2, 8'h55, 1'b0, 0, 0, 2);
    check("nobyp B rd1_data", s_data[1][1], 8'h44);
    check("nobyp B rd1_busy", 8'(s_busy[1][1]), 8'h01);
    check("byp A rd1_data", s_data[0][1], 8'h55);
    check("byp A rd1_busy", 8'(s_busy[0][1]), 8'h00);
    idle(0, 2);
    check("after wr B rd1_data", s_data[1][1], 8'h55);
    check("after wr B rd1_busy", 8'(s_busy[1][1]), 8'h00);

    // Out-of-range indices on B (6, 7): ignored, read as zero and never busy.
    cycle(1'b0, 1'b1, 7, 8'h77, 1'b1, 6, 0, 0);
    idle(7, 6);
    check("oor B rd0_data", s_data[1][0], 8'h00);
    check("oor B rd0_busy", 8'(s_busy[1][0]), 8'h00);
    check("oor B rd1_busy", 8'(s_busy[1][1]), 8'h00);
    check("inrange A rd0_data", s_data[0][0], 8'h77);
    check("inrange A rd1_busy", 8'(s_busy[0][1]), 8'h01);

    // Reset wins over a simultaneous write.
    cycle(1'b0, 1'b1, 7, 8'h5A, 1'b0, 0, 0, 0);
    cycle(1'b1, 1'b1, 7, 8'h99, 1'b1, 7, 0, 0);
    idle(7, 6);
    check("rst over wr A rd0_data", s_data[0][0], 8'h00);
    check("rst over wr A rd0_busy", 8'(s_busy[0][0]), 8'h00);
    check("rst clears A rd1_busy", 8'(s_busy[0][1]), 8'h00);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
